// File: rtl/chan_scan_pkg.sv
// Shared definitions for the channel scan multiplexer.
//   state_t       : controller states (IDLE, FIND, PRESENT)
//   MODE_MANUAL   : single capture of the channel named by sel_in
//   MODE_SCAN     : sweep over every channel enabled in ch_en
//   idx_in_range  : true when a channel index addresses a real channel
package chan_scan_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FIND    = 2'd1,
    PRESENT = 2'd2
  } state_t;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Index widths are rounded up to a power of two, so an index can name a
  // channel that does not exist when the channel count is not a power of two.
  function automatic logic idx_in_range(input logic [31:0] idx,
                                        input logic [31:0] num_ch);
    return (idx < num_ch);
  endfunction

endpackage

// File: rtl/chan_scan_mux_chan_sel_core.sv
// Combinational NUM_CH:1 word selector.
//   din  : packed channels, channel k = din[k*DATA_W +: DATA_W]
//   sel  : channel index
//   dout : selected word; an index with no matching channel gives zero
module chan_sel_core #(
  parameter int NUM_CH = 8,
  parameter int DATA_W = 8,
  parameter int SEL_W  = 3
) (
  input  logic [NUM_CH*DATA_W-1:0] din,
  input  logic [SEL_W-1:0]         sel,
  output logic [DATA_W-1:0]        dout
);

  // AND-OR selection: each channel contributes only when its index matches,
  // which also gives zero for out-of-range indices without extra logic.
  always_comb begin
    dout = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      dout = dout | (din[k*DATA_W +: DATA_W] & {DATA_W{sel == SEL_W'(k)}});
    end
  end

endmodule

// File: rtl/chan_scan_mux.sv
// Registered NUM_CH:1 channel multiplexer with manual and scan modes.
//   clk, rst_n        : rising-edge clock, asynchronous active-low reset
//   din               : packed input channels
//   ch_en, mode,
//   sel_in, start     : operation request, sampled only when start is taken
//   out_data, out_ch,
//   out_valid,
//   out_ready         : valid/ready result port
//   busy              : operation in progress
//   done, err         : one-cycle end-of-operation and bad-index pulses
module chan_scan_mux
  import chan_scan_pkg::*;
#(
  parameter  int NUM_CH = 8,
  parameter  int DATA_W = 8,
  localparam int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH*DATA_W-1:0] din,
  input  logic [NUM_CH-1:0]        ch_en,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         sel_in,
  input  logic                     start,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_ch,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_CH - 1);

  state_t              state_r, state_s;
  logic                mode_r, mode_s;
  logic [NUM_CH-1:0]   mask_r, mask_s;
  logic [SEL_W-1:0]    idx_r, idx_s;
  logic [DATA_W-1:0]   out_data_r, out_data_s;
  logic [SEL_W-1:0]    out_ch_r, out_ch_s;
  logic                out_valid_r, out_valid_s;
  logic                busy_r, busy_s;
  logic                done_r, done_s;
  logic                err_r, err_s;
  logic [SEL_W-1:0]    core_sel_s;
  logic [DATA_W-1:0]   core_word_s;
  logic                sel_ok_s;

  // In IDLE the index register is not loaded yet, so a manual capture must
  // look at sel_in directly to achieve one-cycle latency.
  assign core_sel_s = (state_r == IDLE) ? sel_in : idx_r;
  assign sel_ok_s   = idx_in_range(32'(sel_in), 32'(NUM_CH));

  chan_sel_core #(
    .NUM_CH (NUM_CH),
    .DATA_W (DATA_W),
    .SEL_W  (SEL_W)
  ) u_sel (
    .din  (din),
    .sel  (core_sel_s),
    .dout (core_word_s)
  );

  // Next-state, datapath load and pulse generation.
  always_comb begin
    state_s     = state_r;
    mode_s      = mode_r;
    mask_s      = mask_r;
    idx_s       = idx_r;
    out_data_s  = out_data_r;
    out_ch_s    = out_ch_r;
    out_valid_s = out_valid_r;
    done_s      = 1'b0;
    err_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          mode_s = mode;
          mask_s = ch_en;
          if (mode == MODE_SCAN) begin
            idx_s   = '0;
            state_s = FIND;
          end else if (sel_ok_s) begin
            idx_s       = sel_in;
            out_data_s  = core_word_s;
            out_ch_s    = sel_in;
            out_valid_s = 1'b1;
            state_s     = PRESENT;
          end else begin
            idx_s  = sel_in;
            err_s  = 1'b1;
            done_s = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end
      FIND: begin
        if (mask_r[idx_r]) begin
          out_data_s  = core_word_s;
          out_ch_s    = idx_r;
          out_valid_s = 1'b1;
          state_s     = PRESENT;
        end else if (idx_r == LAST_IDX) begin
          done_s  = 1'b1;
          state_s = IDLE;
        end else begin
          idx_s = idx_r + SEL_W'(1);
        end
      end
      PRESENT: begin
        // out_valid is always set in this state, so out_ready alone
        // completes the handshake.
        if (out_ready) begin
          out_valid_s = 1'b0;
          if ((mode_r == MODE_MANUAL) || (idx_r == LAST_IDX)) begin
            done_s  = 1'b1;
            state_s = IDLE;
          end else begin
            idx_s   = idx_r + SEL_W'(1);
            state_s = FIND;
          end
        end else begin
          state_s = PRESENT;
        end
      end
      default: begin
        out_valid_s = 1'b0;
        state_s     = IDLE;
      end
    endcase
    busy_s = (state_s != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      mode_r      <= MODE_MANUAL;
      mask_r      <= '0;
      idx_r       <= '0;
      out_data_r  <= '0;
      out_ch_r    <= '0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      state_r     <= state_s;
      mode_r      <= mode_s;
      mask_r      <= mask_s;
      idx_r       <= idx_s;
      out_data_r  <= out_data_s;
      out_ch_r    <= out_ch_s;
      out_valid_r <= out_valid_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
      err_r       <= err_s;
    end
  end

  assign out_data  = out_data_r;
  assign out_ch    = out_ch_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign err       = err_r;

endmodule

// File: tb/tb_chan_scan_mux.sv
// Directed bench for chan_scan_mux: an 8-channel instance for the main
// function and a 6-channel instance for out-of-range manual indices.
module tb_chan_scan_mux;

  logic        clk;
  logic        rst_n;

  // 8-channel instance
  logic [63:0] din;
  logic [7:0]  ch_en;
  logic        mode;
  logic [2:0]  sel_in;
  logic        start;
  logic [7:0]  out_data;
  logic [2:0]  out_ch;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;
  logic        err;

  // 6-channel instance
  logic [47:0] din6;
  logic [5:0]  ch_en6;
  logic        mode6;
  logic [2:0]  sel6;
  logic        start6;
  logic [7:0]  out_data6;
  logic [2:0]  out_ch6;
  logic        out_valid6;
  logic        out_ready6;
  logic        busy6;
  logic        done6;
  logic        err6;

  int checks   = 0;
  int failures = 0;

  logic [7:0] got_data [8];
  logic [2:0] got_ch   [8];

  typedef struct {
    logic [2:0] sel;
    logic [7:0] exp_data;
    logic [2:0] exp_ch;
    int         wait_n;
  } man_vec_t;

  man_vec_t man_tab [4];

  chan_scan_mux #(.NUM_CH(8), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .ch_en(ch_en), .mode(mode),
    .sel_in(sel_in), .start(start), .out_data(out_data), .out_ch(out_ch),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
    .done(done), .err(err)
  );

  chan_scan_mux #(.NUM_CH(6), .DATA_W(8)) dut6 (
    .clk(clk), .rst_n(rst_n), .din(din6), .ch_en(ch_en6), .mode(mode6),
    .sel_in(sel6), .start(start6), .out_data(out_data6), .out_ch(out_ch6),
    .out_valid(out_valid6), .out_ready(out_ready6), .busy(busy6),
    .done(done6), .err(err6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_din_default();
    for (int k = 0; k < 8; k++) din[k*8 +: 8] = 8'h10 + 8'(k);
    for (int k = 0; k < 6; k++) din6[k*8 +: 8] = 8'h20 + 8'(k);
  endtask

  // Runs one scan on the 8-channel instance, recording every presented word.
  // With noisy_start, start stays high with other settings for the whole
  // operation, including the edge of the final handshake.
  task automatic run_scan(input logic [7:0] en, input int stall_ch, input int stall_n,
                          input bit noisy_start, output int nwords, output int ndone);
    bit stalled;
    bit fin;
    nwords = 0; ndone = 0; stalled = 0; fin = 0;
    ch_en = en; mode = 1'b1; sel_in = 3'd0; out_ready = 1'b1; start = 1'b1;
    tick();
    ch_en = ~en; mode = 1'b0; sel_in = 3'd3;
    start = noisy_start;
    for (int cyc = 0; cyc < 60 && !fin; cyc++) begin
      if (out_valid) begin
        if (nwords < 8) begin
          got_data[nwords] = out_data;
          got_ch[nwords]   = out_ch;
        end
        nwords++;
        if (stall_ch >= 0 && int'(out_ch) == stall_ch && !stalled) begin
          stalled = 1;
          out_ready = 1'b0;
          for (int s = 0; s < stall_n; s++) begin
            din[stall_ch*8 +: 8] = 8'hE0 + 8'(s);
            tick();
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_data", 32'(out_data), 32'h10 + 32'(stall_ch));
            chk("stall_ch", 32'(out_ch), 32'(stall_ch));
          end
          din[stall_ch*8 +: 8] = 8'h10 + 8'(stall_ch);
          out_ready = 1'b1;
        end
      end
      tick();
      if (done) begin
        ndone++;
        fin = 1;
        start = 1'b0;
      end
    end
    start = 1'b0;
    if (!fin) chk("scan_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_scan_a5(input string tag, input int nwords, input int ndone);
    int exp_ch [4];
    logic [7:0] exp_data [4];
    exp_ch   = '{0, 2, 5, 7};
    exp_data = '{8'h10, 8'h12, 8'h15, 8'h17};
    chk({tag, "_nwords"}, 32'(nwords), 32'd4);
    chk({tag, "_ndone"}, 32'(ndone), 32'd1);
    for (int i = 0; i < 4 && i < nwords; i++) begin
      chk({tag, "_data"}, 32'(got_data[i]), 32'(exp_data[i]));
      chk({tag, "_ch"}, 32'(got_ch[i]), 32'(exp_ch[i]));
    end
    tick();
    chk({tag, "_post_done"}, 32'(done), 32'd0);
    chk({tag, "_post_busy"}, 32'(busy), 32'd0);
    chk({tag, "_post_valid"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int nw;
    int nd;

    man_tab[0] = '{sel: 3'd5, exp_data: 8'h15, exp_ch: 3'd5, wait_n: 0};
    man_tab[1] = '{sel: 3'd0, exp_data: 8'h10, exp_ch: 3'd0, wait_n: 2};
    man_tab[2] = '{sel: 3'd7, exp_data: 8'h17, exp_ch: 3'd7, wait_n: 1};
    man_tab[3] = '{sel: 3'd3, exp_data: 8'h13, exp_ch: 3'd3, wait_n: 0};

    rst_n = 1'b0;
    ch_en = 8'h00; mode = 1'b0; sel_in = 3'd0; start = 1'b0; out_ready = 1'b1;
    ch_en6 = 6'h00; mode6 = 1'b0; sel6 = 3'd0; start6 = 1'b0; out_ready6 = 1'b1;
    din = '0; din6 = '0;
    set_din_default();
    @(posedge clk); @(posedge clk);
    #3 rst_n = 1'b1;
    tick();

    // Reset state
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_ch", 32'(out_ch), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);

    // Manual captures, table driven
    for (int v = 0; v < 4; v++) begin
      mode = 1'b0; sel_in = man_tab[v].sel;
      out_ready = (man_tab[v].wait_n == 0);
      start = 1'b1;
      tick();
      start = 1'b0; sel_in = ~man_tab[v].sel;
      chk("man_valid", 32'(out_valid), 32'd1);
      chk("man_data", 32'(out_data), 32'(man_tab[v].exp_data));
      chk("man_ch", 32'(out_ch), 32'(man_tab[v].exp_ch));
      chk("man_busy", 32'(busy), 32'd1);
      for (int w = 0; w < man_tab[v].wait_n; w++) begin
        tick();
        chk("man_hold_valid", 32'(out_valid), 32'd1);
        chk("man_hold_data", 32'(out_data), 32'(man_tab[v].exp_data));
      end
      out_ready = 1'b1;
      tick();
      chk("man_end_valid", 32'(out_valid), 32'd0);
      chk("man_end_done", 32'(done), 32'd1);
      chk("man_end_busy", 32'(busy), 32'd0);
      chk("man_keep_data", 32'(out_data), 32'(man_tab[v].exp_data));
      tick();
      chk("man_done_pulse", 32'(done), 32'd0);
    end

    // Scan sweep over channels 0, 2, 5, 7
    run_scan(8'hA5, -1, 0, 1'b0, nw, nd);
    check_scan_a5("scan", nw, nd);

    // Scan with a 6-cycle stall on channel 2 while its input changes
    run_scan(8'hA5, 2, 6, 1'b0, nw, nd);
    check_scan_a5("stall", nw, nd);

    // Scan with start held high throughout, including the final handshake
    run_scan(8'hA5, -1, 0, 1'b1, nw, nd);
    check_scan_a5("busystart", nw, nd);

    // All channels disabled: done exactly 8 cycles after the start edge
    ch_en = 8'h00; mode = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i < 8; i++) begin
      chk("empty_busy", 32'(busy), 32'd1);
      chk("empty_done", 32'(done), 32'd0);
      chk("empty_valid", 32'(out_valid), 32'd0);
      tick();
    end
    chk("empty_busy_last", 32'(busy), 32'd1);
    tick();
    chk("empty_done_end", 32'(done), 32'd1);
    chk("empty_busy_end", 32'(busy), 32'd0);
    chk("empty_valid_end", 32'(out_valid), 32'd0);
    tick();
    chk("empty_done_pulse", 32'(done), 32'd0);

    // 6-channel instance: out-of-range manual indices, then a valid one
    mode6 = 1'b0; sel6 = 3'd7; start6 = 1'b1;
    tick();
    start6 = 1'b0;
    chk("oor7_err", 32'(err6), 32'd1);
    chk("oor7_done", 32'(done6), 32'd1);
    chk("oor7_valid", 32'(out_valid6), 32'd0);
    chk("oor7_busy", 32'(busy6), 32'd0);
    tick();
    chk("oor7_err_pulse", 32'(err6), 32'd0);
    chk("oor7_done_pulse", 32'(done6), 32'd0);
    sel6 = 3'd6; start6 = 1'b1;
    tick();
    start6 = 1'b0;
    chk("oor6_err", 32'(err6), 32'd1);
    chk("oor6_valid", 32'(out_valid6), 32'd0);
    sel6 = 3'd5; start6 = 1'b1;
    tick();
    start6 = 1'b0;
    chk("ch6_err", 32'(err6), 32'd0);
    chk("ch6_valid", 32'(out_valid6), 32'd1);
    chk("ch6_data", 32'(out_data6), 32'h25);
    chk("ch6_ch", 32'(out_ch6), 32'd5);
    tick();
    chk("ch6_done", 32'(done6), 32'd1);

    // Reset in the middle of a scan while a word is presented
    ch_en = 8'hA5; mode = 1'b1; out_ready = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("mid_valid", 32'(out_valid), 32'd1);
    chk("mid_data", 32'(out_data), 32'h10);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_data", 32'(out_data), 32'd0);
    chk("arst_ch", 32'(out_ch), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_err", 32'(err), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rel_done", 32'(done), 32'd0);
      chk("rel_busy", 32'(busy), 32'd0);
      chk("rel_valid", 32'(out_valid), 32'd0);
    end
    mode = 1'b0; sel_in = 3'd3; start = 1'b1;
    tick();
    start = 1'b0;
    chk("fresh_valid", 32'(out_valid), 32'd1);
    chk("fresh_data", 32'(out_data), 32'h13);
    chk("fresh_ch", 32'(out_ch), 32'd3);
    tick();
    chk("fresh_done", 32'(done), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/chan_scan_mux.md
Name: chan_scan_mux

Overview:
Parametrised, registered N:1 channel multiplexer. It is the sequential successor to the combinational 8:1 selector. It supports two modes:
- Manual mode: a single capture of the selected channel.
- Scan mode: a sweep over all enabled channels.

Results leave on a valid/ready output port, so a downstream serialiser or logger can apply backpressure. It sits between parallel sensor/data channels and a single shared consumer.

Parameters:
NUM_CH, 8, number of input channels (>=2)
DATA_W, 8, width of each channel word (>=1)
SEL_W, $clog2(NUM_CH), derived localparam, width of channel index (not overridable)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
din  input  NUM_CH*DATA_W  packed channels; channel k = din[k*DATA_W +: DATA_W]
ch_en  input  NUM_CH  per-channel enable mask, used in scan mode; sampled at start
mode  input  1  0 = manual single capture, 1 = scan sweep; sampled at start
sel_in  input  SEL_W  channel index for manual mode; sampled at start
start  input  1  one-cycle request; ignored while busy=1
out_data  output  DATA_W  captured channel word
out_ch  output  SEL_W  index of channel in out_data
out_valid  output  1  out_data/out_ch valid
out_ready  input  1  consumer accepts when out_valid & out_ready
busy  output  1  high from cycle after accepted start until operation ends
done  output  1  one-cycle pulse when operation ends
err  output  1  one-cycle pulse: manual start with sel_in >= NUM_CH

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; out_data=0, out_ch=0, out_valid=0, busy=0, done=0, err=0; mask register=0.
  - Reset mid-operation aborts immediately. No done pulse on release.
- States: IDLE, FIND, PRESENT.
- IDLE:
  - start=1 latches mode, ch_en->mask, sel_in->idx.
  - Manual, idx<NUM_CH: go PRESENT. On the same edge load out_data=din[idx], out_ch=idx, out_valid=1. Latency start->out_valid is 1 cycle.
  - Manual, idx>=NUM_CH (only possible when NUM_CH is not a power of 2): err=1 and done=1 for one cycle, stay IDLE, no valid.
  - Scan: idx=0, go FIND.
  - busy=1 in every non-IDLE state.
- FIND (scan only):
  - Examines one channel per cycle.
  - mask[idx]=1: load out_data=din[idx], out_ch=idx, out_valid=1, go PRESENT.
  - mask[idx]=0 and idx<NUM_CH-1: idx++.
  - mask[idx]=0 and idx==NUM_CH-1: done=1, go IDLE.
  - All-disabled mask: done NUM_CH cycles after start; out_valid never asserts.
- PRESENT:
  - out_data and out_ch are held stable while out_valid & !out_ready. Data is captured at load and not re-sampled from din.
  - On handshake, manual mode: out_valid=0, done=1, go IDLE.
  - On handshake, scan mode with idx==NUM_CH-1: out_valid=0, done=1, go IDLE.
  - On handshake, scan mode otherwise: out_valid=0, idx++, go FIND.
  - Minimum scan throughput is 1 word per 2 cycles. Back-to-back valids are not required.
- done and err are single-cycle pulses, asserted in the cycle after the deciding edge. busy deasserts on the same edge that done asserts.
- start while busy: ignored, no side effects.
- start on the same edge as a final handshake: ignored. A new start is accepted from IDLE only.
- Changes to ch_en, mode or sel_in after start have no effect until the next start.
- out_data/out_ch keep their last values after out_valid drops; they are not cleared.

Decomposition:
- Shared package chan_scan_pkg:
  - state enum (IDLE, FIND, PRESENT)
  - MODE_MANUAL=1'b0, MODE_SCAN=1'b1
- One natural sub-module: chan_sel_core, a combinational parametrised NUM_CH:1, DATA_W-bit selector (index -> word, with out-of-range = 0).
  - It generalises the existing 8:1 selector.
  - It is instantiated once, driven by idx.

Test Plan:
1. NUM_CH=8, DATA_W=8, din channel k = 8'h10+k; mode=0, sel_in=5, start, out_ready=1.
   -> Next cycle out_valid=1, out_data=8'h15, out_ch=5. Handshake, then done pulse, busy=0.
2. Scan with ch_en=8'b1010_0101, out_ready=1.
   -> Words 8'h10, 8'h12, 8'h15, 8'h17 on out_ch 0, 2, 5, 7 in that order, then exactly one done pulse.
3. Backpressure in scan: out_ready=0 for 6 cycles on channel 2, change din during stall.
   -> out_data stays 8'h12, out_ch stays 2; no channel skipped or duplicated.
4. ch_en=8'h00, scan start.
   -> out_valid never rises; done pulses 8 cycles after start; busy high for those cycles.
5. NUM_CH=6: manual sel_in=7.
   -> err and done pulse together, no valid. Then start while busy during a scan: ignored, sequence unchanged.
6. Assert rst_n=0 mid-scan (out_valid=1).
   -> All outputs 0 asynchronously; after release, idle with no done; a fresh start works normally.
